// File: rtl/motor_pkg.sv
// Shared types and helpers for the H-bridge motor PWM driver.
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_RAMP = 2'd2,
    ST_RUN  = 2'd3
  } ch_state_e;

  localparam logic [1:0] DIR_FWD = 2'b01;
  localparam logic [1:0] DIR_REV = 2'b10;

  // Only forward or reverse may ever reach the bridge.
  function automatic logic dir_legal(input logic [1:0] code);
    return (code == DIR_FWD) || (code == DIR_REV);
  endfunction

endpackage

// File: rtl/motor_pwm_driver_if.sv
// Decision-logic request bus and H-bridge drive pins for the motor PWM driver.
interface motor_pwm_driver_if;

  logic [3:0] motorIn;
  logic [1:0] motorEn;
  logic [3:0] hb_in;
  logic [1:0] hb_en;
  logic [1:0] ramping;

  modport master (output motorIn, motorEn, input hb_in, hb_en, ramping);
  modport slave  (input motorIn, motorEn, output hb_in, hb_en, ramping);

endinterface

// File: rtl/motor_channel.sv
// One H-bridge channel: dead-time, soft-start ramp, run, and PWM compare.
module motor_channel
  import motor_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DUTY_MAX    = 200,
  parameter int unsigned RAMP_STEP   = 8,
  parameter int unsigned RAMP_DIV    = 1000,
  parameter int unsigned DEAD_CYCLES = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_on,
  input  logic [1:0]          req_dir,
  input  logic [PWM_BITS-1:0] pwm_nxt,
  output logic [1:0]          hb_in,
  output logic                hb_en,
  output logic                ramping
);

  localparam int unsigned DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int unsigned DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned SUM_W  = PWM_BITS + 1;
  localparam int unsigned FIRST_I = (RAMP_STEP < DUTY_MAX) ? RAMP_STEP : DUTY_MAX;

  localparam logic [DEAD_W-1:0]   DEAD_LAST  = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_TOP   = PWM_BITS'(DUTY_MAX);
  localparam logic [PWM_BITS-1:0] DUTY_FIRST = PWM_BITS'(FIRST_I);
  localparam logic [SUM_W-1:0]    STEP_X     = SUM_W'(RAMP_STEP);
  localparam logic [SUM_W-1:0]    MAX_X      = SUM_W'(DUTY_MAX);

  ch_state_e           state_q, state_d;
  logic [1:0]          dir_q, dir_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  logic [DIV_W-1:0]    tmr_q, tmr_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [SUM_W-1:0]    duty_sum;
  logic [PWM_BITS-1:0] duty_inc;
  logic                drive_d;

  // Widened add then clamp, so the duty can never wrap past DUTY_MAX.
  always_comb begin
    duty_sum = {1'b0, duty_q} + STEP_X;
    duty_inc = (duty_sum >= MAX_X) ? DUTY_TOP : duty_sum[PWM_BITS-1:0];
  end

  // Next state: disable beats direction change beats counter expiry.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    tmr_d   = tmr_q;
    duty_d  = duty_q;
    unique case (state_q)
      ST_IDLE: begin
        duty_d = '0;
        if (req_on) begin
          state_d = ST_DEAD;
          dir_d   = req_dir;
          dead_d  = '0;
        end
      end
      ST_DEAD: begin
        if (!req_on) begin
          state_d = ST_IDLE;
        end else if (req_dir != dir_q) begin
          dir_d  = req_dir;
          dead_d = '0;
        end else if (dead_q == DEAD_LAST) begin
          duty_d  = DUTY_FIRST;
          tmr_d   = '0;
          state_d = (DUTY_FIRST == DUTY_TOP) ? ST_RUN : ST_RAMP;
        end else begin
          dead_d = dead_q + DEAD_W'(1);
        end
      end
      ST_RAMP, ST_RUN: begin
        if (!req_on) begin
          state_d = ST_IDLE;
          duty_d  = '0;
        end else if (req_dir != dir_q) begin
          state_d = ST_DEAD;
          dir_d   = req_dir;
          duty_d  = '0;
          dead_d  = '0;
        end else if (state_q == ST_RAMP) begin
          if (tmr_q == DIV_LAST) begin
            tmr_d  = '0;
            duty_d = duty_inc;
            if (duty_inc == DUTY_TOP) state_d = ST_RUN;
          end else begin
            tmr_d = tmr_q + DIV_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign drive_d = (state_d == ST_RAMP) || (state_d == ST_RUN);

  // Outputs come from the next state so DEAD never exposes a direction code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= '0;
      dead_q  <= '0;
      tmr_q   <= '0;
      duty_q  <= '0;
      hb_in   <= '0;
      hb_en   <= 1'b0;
      ramping <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      tmr_q   <= tmr_d;
      duty_q  <= duty_d;
      hb_in   <= drive_d ? dir_d : 2'b00;
      hb_en   <= drive_d && (pwm_nxt < duty_d);
      ramping <= (state_d == ST_DEAD) || (state_d == ST_RAMP);
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Two-channel H-bridge driver: input registers, shared PWM counter, channel mapping.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DUTY_MAX    = 200,
  parameter int unsigned RAMP_STEP   = 8,
  parameter int unsigned RAMP_DIV    = 1000,
  parameter int unsigned DEAD_CYCLES = 500
) (
  input logic               clk,
  input logic               rst,
  motor_pwm_driver_if.slave bus
);

  logic [3:0]          motor_in_q;
  logic [1:0]          motor_en_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic [PWM_BITS-1:0] pwm_nxt;
  logic                req_on_a, req_on_b;
  logic [1:0]          hb_in_a, hb_in_b;
  logic                hb_en_a, hb_en_b;
  logic                ramp_a, ramp_b;

  assign pwm_nxt = pwm_q + PWM_BITS'(1);

  // Upstream decision logic is combinational, so register it once here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      motor_in_q <= '0;
      motor_en_q <= '0;
      pwm_q      <= '0;
    end else begin
      motor_in_q <= bus.motorIn;
      motor_en_q <= bus.motorEn;
      pwm_q      <= pwm_nxt;
    end
  end

  assign req_on_a = motor_en_q[1] && dir_legal(motor_in_q[3:2]);
  assign req_on_b = motor_en_q[0] && dir_legal(motor_in_q[1:0]);

  motor_channel #(
    .PWM_BITS(PWM_BITS), .DUTY_MAX(DUTY_MAX), .RAMP_STEP(RAMP_STEP),
    .RAMP_DIV(RAMP_DIV), .DEAD_CYCLES(DEAD_CYCLES)
  ) u_ch_a (
    .clk(clk), .rst(rst), .req_on(req_on_a), .req_dir(motor_in_q[3:2]),
    .pwm_nxt(pwm_nxt), .hb_in(hb_in_a), .hb_en(hb_en_a), .ramping(ramp_a)
  );

  motor_channel #(
    .PWM_BITS(PWM_BITS), .DUTY_MAX(DUTY_MAX), .RAMP_STEP(RAMP_STEP),
    .RAMP_DIV(RAMP_DIV), .DEAD_CYCLES(DEAD_CYCLES)
  ) u_ch_b (
    .clk(clk), .rst(rst), .req_on(req_on_b), .req_dir(motor_in_q[1:0]),
    .pwm_nxt(pwm_nxt), .hb_in(hb_in_b), .hb_en(hb_en_b), .ramping(ramp_b)
  );

  assign bus.hb_in   = {hb_in_a, hb_in_b};
  assign bus.hb_en   = {hb_en_a, hb_en_b};
  assign bus.ramping = {ramp_a, ramp_b};

endmodule
